// File: rtl/simd_pkg.sv
// Shared types and default sizing for the SIMD lane scheduler.
// The thread index is 4 bits wide, so a lane can hold at most 16 threads.
package simd_pkg;

    localparam int NUM_THREADS = 16;
    localparam int PIPE_DEPTH  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic [4:0]  funct4;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        is_int;
        logic        is_float;
        logic        we;
    } issue_t;

    // One in-flight register write that is still in the lane pipeline.
    typedef struct packed {
        logic       valid;
        logic [3:0] tidx;
        logic [4:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/thread_picker.sv
// Rotating find-first-set: returns the lowest set bit at or above ptr.
// If there is no such bit, it wraps around and returns the lowest set bit overall.
module thread_picker #(
    parameter int NUM_THREADS = 16
) (
    input  logic [NUM_THREADS-1:0] mask,
    input  logic [3:0]             ptr,
    output logic [3:0]             idx,
    output logic                   found
);

    logic [3:0] hi_idx;
    logic [3:0] lo_idx;
    logic       hi_found;
    logic       lo_found;

    // Scan downward so that the last hit in each class is the lowest index.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lo_idx   = 4'(i);
                lo_found = 1'b1;
                if (4'(i) >= ptr) begin
                    hi_idx   = 4'(i);
                    hi_found = 1'b1;
                end
            end
        end
        idx   = hi_found ? hi_idx : lo_idx;
        found = lo_found;
    end

endmodule

// File: rtl/lane_scheduler.sv
// Takes a decoded instruction and issues it once per thread in its mask.
// Issue is in rotating order, and a bubble is inserted while a scoreboard hazard is present.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a new instruction; nothing issues
// ISSUE | walking the pending mask, one thread per unstalled cycle
module lane_scheduler #(
    parameter int NUM_THREADS = simd_pkg::NUM_THREADS,
    parameter int PIPE_DEPTH  = simd_pkg::PIPE_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [4:0]             instr_funct4,
    input  logic [31:0]            instr_imm,
    input  logic [4:0]             instr_rs1,
    input  logic [4:0]             instr_rs2,
    input  logic [4:0]             instr_rd,
    input  logic                   instr_is_int,
    input  logic                   instr_is_float,
    input  logic                   instr_we,
    input  logic [NUM_THREADS-1:0] thread_mask,
    input  logic                   stall_in,
    output logic                   issue_valid,
    output logic [3:0]             tIdx,
    output logic [4:0]             FUNCT4,
    output logic [31:0]            IMM,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    output logic [4:0]             rd,
    output logic                   is_int,
    output logic                   is_float,
    output logic                   WE3,
    output logic                   stall,
    output logic                   done
);
    import simd_pkg::*;

    sched_state_t           state;
    sched_state_t           state_nxt;
    issue_t                 cap;
    issue_t                 instr_in;
    logic [NUM_THREADS-1:0] pending;
    logic [NUM_THREADS-1:0] clr_bit;
    logic [3:0]             ptr;
    logic [3:0]             ptr_nxt;
    logic                   zero_done;
    sb_entry_t              sb [PIPE_DEPTH];

    logic [3:0] cand;
    logic       found;
    logic       hazard;
    logic       accept;
    logic       issue;
    logic       last_issue;

    thread_picker #(
        .NUM_THREADS(NUM_THREADS)
    ) u_picker (
        .mask  (pending),
        .ptr   (ptr),
        .idx   (cand),
        .found (found)
    );

    always_comb begin
        instr_in          = '0;
        instr_in.funct4   = instr_funct4;
        instr_in.imm      = instr_imm;
        instr_in.rs1      = instr_rs1;
        instr_in.rs2      = instr_rs2;
        instr_in.rd       = instr_rd;
        instr_in.is_int   = instr_is_int;
        instr_in.is_float = instr_is_float;
        instr_in.we       = instr_we;
    end

    // rs2 only counts as a source when the operation does not take the immediate.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (sb[i].valid && (sb[i].tidx == cand) &&
                ((sb[i].rd == cap.rs1) || (!cap.funct4[4] && (sb[i].rd == cap.rs2))))
                hazard = 1'b1;
        end
    end

    always_comb begin
        clr_bit = '0;
        for (int i = 0; i < NUM_THREADS; i++)
            clr_bit[i] = (4'(i) == cand);
    end

    assign accept     = (state == IDLE) && instr_valid;
    assign issue      = (state == ISSUE) && found && !stall_in && !hazard;
    assign last_issue = issue && ((pending & ~clr_bit) == '0);
    assign ptr_nxt    = (cand == 4'(NUM_THREADS - 1)) ? 4'd0 : cand + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        issue_valid = 1'b0;
        WE3         = 1'b0;
        done        = zero_done;
        tIdx        = cand;
        FUNCT4      = cap.funct4;
        IMM         = cap.imm;
        rs1         = cap.rs1;
        rs2         = cap.rs2;
        rd          = cap.rd;
        is_int      = cap.is_int;
        is_float    = cap.is_float;
        stall       = stall_in;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid && (thread_mask != '0))
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                issue_valid = issue;
                WE3         = issue && cap.we;
                done        = last_issue;
                if (last_issue)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // An empty mask is acknowledged with a done pulse one cycle after accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap       <= '0;
            pending   <= '0;
            ptr       <= '0;
            zero_done <= 1'b0;
        end else begin
            zero_done <= accept && (thread_mask == '0);
            if (accept) begin
                cap     <= instr_in;
                pending <= thread_mask;
                ptr     <= '0;
            end else if (issue) begin
                pending <= pending & ~clr_bit;
                ptr     <= ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++)
                sb[i] <= '0;
        end else if (!stall_in) begin
            sb[0] <= '{valid: issue && cap.we && (cap.rd != '0), tidx: cand, rd: cap.rd};
            for (int i = 1; i < PIPE_DEPTH; i++)
                sb[i] <= sb[i-1];
        end
    end

endmodule

// File: tb/tb_lane_scheduler.sv
// Directed bench for lane_scheduler.
// A write-history model checks every cycle, and literal checks pin the key scenarios.
module tb_lane_scheduler;
    localparam int NT = 16;
    localparam int PD = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          instr_valid;
    logic          instr_ready;
    logic [4:0]    instr_funct4;
    logic [31:0]   instr_imm;
    logic [4:0]    instr_rs1, instr_rs2, instr_rd;
    logic          instr_is_int, instr_is_float, instr_we;
    logic [NT-1:0] thread_mask;
    logic          stall_in;
    logic          issue_valid;
    logic [3:0]    tIdx;
    logic [4:0]    FUNCT4;
    logic [31:0]   IMM;
    logic [4:0]    rs1, rs2, rd;
    logic          is_int, is_float, WE3, stall, done;

    lane_scheduler #(.NUM_THREADS(NT), .PIPE_DEPTH(PD)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_funct4(instr_funct4), .instr_imm(instr_imm),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
        .instr_is_int(instr_is_int), .instr_is_float(instr_is_float), .instr_we(instr_we),
        .thread_mask(thread_mask), .stall_in(stall_in),
        .issue_valid(issue_valid), .tIdx(tIdx),
        .FUNCT4(FUNCT4), .IMM(IMM), .rs1(rs1), .rs2(rs2), .rd(rd),
        .is_int(is_int), .is_float(is_float), .WE3(WE3),
        .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a thread may not read a register that it wrote in the last PD unstalled cycles.
    typedef struct { int cnt; int t; int rd; } wr_t;
    wr_t           hist[$];
    bit            m_busy = 0;
    bit            m_zd   = 0;
    bit [NT-1:0]   m_pend = '0;
    int            m_ptr  = 0;
    int            m_cnt  = 0;
    logic [4:0]    c_f4 = '0, c_rs1 = '0, c_rs2 = '0, c_rd = '0;
    logic [31:0]   c_imm = '0;
    logic          c_int = 1'b0, c_flt = 1'b0, c_we = 1'b0;

    always @(negedge clk) begin
        int          cand;
        int          age;
        bit          haz, iss, dn;
        bit [NT-1:0] rem;
        if (!reset) begin
            chk("m_rst_ready", instr_ready, 1);
            chk("m_rst_valid", issue_valid, 0);
            chk("m_rst_we3",   WE3, 0);
            chk("m_rst_done",  done, 0);
            chk("m_rst_fields", {FUNCT4, rs1, rs2, rd, is_int, is_float}, 0);
            chk("m_rst_imm",   IMM, 0);
            m_busy = 0; m_zd = 0; m_pend = '0; m_ptr = 0;
            hist.delete();
            c_f4 = '0; c_rs1 = '0; c_rs2 = '0; c_rd = '0; c_imm = '0;
            c_int = 0; c_flt = 0; c_we = 0;
        end else begin
            cand = -1; haz = 0; iss = 0;
            if (m_busy) begin
                for (int i = 0; i < NT; i++)
                    if (cand < 0 && m_pend[(m_ptr + i) % NT]) cand = (m_ptr + i) % NT;
                foreach (hist[k]) begin
                    age = m_cnt - hist[k].cnt;
                    if (hist[k].t == cand && age >= 1 && age <= PD &&
                        (hist[k].rd == int'(c_rs1) || (!c_f4[4] && hist[k].rd == int'(c_rs2))))
                        haz = 1;
                end
                iss = !stall_in && !haz;
            end
            rem = m_pend;
            if (iss) rem[cand] = 1'b0;
            dn = m_zd || (iss && rem == '0);
            chk("m_ready", instr_ready, !m_busy);
            chk("m_valid", issue_valid, iss);
            chk("m_we3",   WE3, iss && c_we);
            chk("m_done",  done, dn);
            chk("m_stall", stall, stall_in);
            chk("m_fields", {FUNCT4, rs1, rs2, rd, is_int, is_float}, {c_f4, c_rs1, c_rs2, c_rd, c_int, c_flt});
            chk("m_imm",   IMM, c_imm);
            if (iss) chk("m_tidx", tIdx, cand);

            if (iss && c_we && c_rd != 0) hist.push_back('{m_cnt, cand, int'(c_rd)});
            if (!stall_in) m_cnt++;
            while (hist.size() > 0 && m_cnt - hist[0].cnt > PD) void'(hist.pop_front());
            m_zd = 0;
            if (!m_busy) begin
                if (instr_valid) begin
                    c_f4 = instr_funct4; c_imm = instr_imm; c_rs1 = instr_rs1;
                    c_rs2 = instr_rs2; c_rd = instr_rd; c_int = instr_is_int;
                    c_flt = instr_is_float; c_we = instr_we;
                    if (thread_mask == '0) m_zd = 1;
                    else begin m_busy = 1; m_pend = thread_mask; m_ptr = 0; end
                end
            end else if (iss) begin
                m_pend = rem;
                m_ptr  = (cand + 1) % NT;
                if (rem == '0) m_busy = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] f4, input logic [31:0] imm,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                         input logic we, input logic [NT-1:0] m);
        instr_valid = v; instr_funct4 = f4; instr_imm = imm;
        instr_rs1 = s1; instr_rs2 = s2; instr_rd = d; instr_we = we;
        instr_is_int = f4[0]; instr_is_float = ~f4[0]; thread_mask = m;
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found_k;
        reset = 1'b0; stall_in = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, '0);
        step(); step();
        chk("rst_ready", instr_ready, 1);
        chk("rst_valid", issue_valid, 0);
        chk("rst_done",  done, 0);
        chk("rst_we3",   WE3, 0);
        reset = 1'b1;
        idle(3);

        // Mask 0x5: threads 0 and 2 on consecutive cycles.
        drive(1, 5'h01, 32'h11, 5'd1, 5'd4, 5'd3, 1, 16'h0005);
        @(negedge clk); chk("a0_ready", instr_ready, 1);
        step(); instr_valid = 1'b0;
        @(negedge clk);
        chk("a1_valid", issue_valid, 1); chk("a1_tidx", tIdx, 0);
        chk("a1_we3", WE3, 1); chk("a1_done", done, 0);
        step();
        @(negedge clk);
        chk("a2_valid", issue_valid, 1); chk("a2_tidx", tIdx, 2); chk("a2_done", done, 1);
        step();
        @(negedge clk);
        chk("a3_valid", issue_valid, 0); chk("a3_ready", instr_ready, 1);
        step();
        idle(4);

        // RAW on rd=5: three cycles without issue between the two issues.
        drive(1, 5'h00, 32'h0, 5'd0, 5'd0, 5'd5, 1, 16'h0001);
        @(negedge clk); step();
        drive(1, 5'h02, 32'h22, 5'd5, 5'd0, 5'd6, 1, 16'h0001);
        @(negedge clk);
        chk("b1_valid", issue_valid, 1); chk("b1_ready", instr_ready, 0); chk("b1_done", done, 1);
        step();
        @(negedge clk);
        chk("b2_ready", instr_ready, 1); chk("b2_valid", issue_valid, 0);
        step(); instr_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("b_bubble_valid", issue_valid, 0); chk("b_bubble_we3", WE3, 0);
            step();
        end
        @(negedge clk);
        chk("b5_valid", issue_valid, 1); chk("b5_tidx", tIdx, 0); chk("b5_done", done, 1);
        step();
        idle(4);

        // Same sequence, but the reader uses the immediate: rs2 is ignored, so no bubble.
        drive(1, 5'h00, 32'h0, 5'd0, 5'd0, 5'd5, 1, 16'h0001);
        @(negedge clk); step();
        drive(1, 5'h10, 32'h33, 5'd0, 5'd5, 5'd6, 1, 16'h0001);
        @(negedge clk); chk("c1_valid", issue_valid, 1);
        step();
        @(negedge clk); chk("c2_ready", instr_ready, 1);
        step(); instr_valid = 1'b0;
        @(negedge clk);
        chk("c3_valid", issue_valid, 1); chk("c3_done", done, 1);
        step();
        idle(4);

        // Full mask with a 4-cycle stall after threads 0 and 1.
        drive(1, 5'h03, 32'h44, 5'd1, 5'd2, 5'd7, 1, 16'hFFFF);
        @(negedge clk); step(); instr_valid = 1'b0;
        @(negedge clk); chk("d1_tidx", tIdx, 0); step();
        @(negedge clk); chk("d2_tidx", tIdx, 1); step();
        stall_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("d_stall", stall, 1); chk("d_stall_valid", issue_valid, 0);
            chk("d_stall_we3", WE3, 0);
            step();
        end
        stall_in = 1'b0;
        @(negedge clk);
        chk("d_resume_valid", issue_valid, 1); chk("d_resume_tidx", tIdx, 2);
        step();
        found_k = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done && found_k < 0) found_k = k;
            step();
            if (found_k >= 0) break;
        end
        chk("d_done_pos", found_k, 12);
        idle(4);

        // Empty mask.
        drive(1, 5'h04, 32'h55, 5'd1, 5'd2, 5'd3, 1, 16'h0000);
        @(negedge clk); chk("e0_ready", instr_ready, 1);
        step(); instr_valid = 1'b0;
        @(negedge clk);
        chk("e1_done", done, 1); chk("e1_valid", issue_valid, 0); chk("e1_ready", instr_ready, 1);
        step();
        @(negedge clk); chk("e2_done", done, 0);
        step();
        idle(2);

        // Reset after two of four issues.
        drive(1, 5'h05, 32'hDEADBEEF, 5'd1, 5'd3, 5'd2, 1, 16'h000F);
        @(negedge clk); step(); instr_valid = 1'b0;
        @(negedge clk); chk("f1_tidx", tIdx, 0); step();
        @(negedge clk); chk("f2_tidx", tIdx, 1); step();
        reset = 1'b0;
        #1;
        chk("f_rst_valid", issue_valid, 0); chk("f_rst_we3", WE3, 0);
        chk("f_rst_done", done, 0); chk("f_rst_ready", instr_ready, 1);
        chk("f_rst_imm", IMM, 0); chk("f_rst_funct4", FUNCT4, 0);
        step();
        reset = 1'b1;
        drive(1, 5'h05, 32'h66, 5'd1, 5'd3, 5'd2, 1, 16'h000F);
        @(negedge clk); chk("f_re_done", done, 0);
        step(); instr_valid = 1'b0;
        @(negedge clk);
        chk("f_re_valid", issue_valid, 1); chk("f_re_tidx", tIdx, 0);
        step();
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lane_scheduler.md
LANE_SCHEDULER -- requirements
Module: lane_scheduler

Interface
REQ-001 The module SHALL have parameter NUM_THREADS, default 16, meaning the number of hardware threads; its legal range is 1..16 and it is sized to the 4-bit tIdx.
REQ-002 The module SHALL have parameter PIPE_DEPTH, default 3, meaning the number of lane pipeline stages between issue and register write-back (ID/EX, EX/MEM, MEM/WB).
REQ-003 The module SHALL use one clock, clk; reset SHALL be asynchronous and active-low, with the port named reset.
REQ-004 The module SHALL have these ports, one per line:
- clk  in  1  clock
- reset  in  1  async active-low reset
- instr_valid  in  1  decoded instruction offered
- instr_ready  out  1  scheduler accepts instruction
- instr_funct4  in  5  operation; bit 4 set = use IMM
- instr_imm  in  32  immediate
- instr_rs1 / instr_rs2 / instr_rd  in  5 each  register addresses
- instr_is_int / instr_is_float / instr_we  in  1 each  unit select, write enable
- thread_mask  in  NUM_THREADS  active threads, sampled at accept
- stall_in  in  1  global freeze request
- issue_valid  out  1  lane operands valid this cycle
- tIdx  out  4  thread being issued
- FUNCT4, IMM, rs1, rs2, rd, is_int, is_float, WE3  out  5/32/5/5/5/1/1/1  lane controls
- stall  out  1  lane pipeline freeze
- done  out  1  one-cycle pulse on the final issue of an instruction

Function
REQ-005 The FSM SHALL have two states: IDLE and ISSUE.
REQ-006 In IDLE, instr_ready SHALL be 1; the instruction SHALL be accepted when instr_valid=1, capturing all instr_* fields and thread_mask into pending; in ISSUE, instr_ready SHALL be 0.
REQ-007 On accept with thread_mask=0, the module SHALL pulse done in the next cycle and remain in IDLE.
REQ-008 On accept with a nonzero mask, it SHALL enter ISSUE; the first issue SHALL occur no earlier than the cycle after accept.
REQ-009 In ISSUE, candidate thread = the lowest set pending bit at index >= ptr, wrapping to the lowest set bit overall; ptr SHALL reset to 0 on each accept.
REQ-010 A candidate SHALL issue (issue_valid=1) iff stall_in=0 and no hazard exists; on issue, its pending bit SHALL clear and ptr SHALL become candidate+1 mod NUM_THREADS.
REQ-011 Hazard condition: a valid scoreboard entry with matching tIdx and rd equal to rs1, or to rs2 when FUNCT4[4]=0.
REQ-012 The scoreboard SHALL be a PIPE_DEPTH-entry shift register of {valid, tIdx, rd}; on every cycle with stall_in=0 it SHALL shift in {issue_valid & instr_we & (rd!=0), tIdx, rd}; with stall_in=1 it SHALL hold.
REQ-013 When issue_valid=0, WE3 SHALL be 0 (bubble); lane outputs SHALL otherwise reflect the captured fields and candidate tIdx; WE3 = issue_valid & captured we.
REQ-014 stall SHALL equal stall_in, combinationally; a hazard SHALL NOT assert stall (a bubble is inserted instead).
REQ-015 done SHALL be 1 in the cycle the last pending bit issues; the FSM SHALL return to IDLE on the next edge.
REQ-016 instr_ready SHALL NOT depend combinationally on instr_valid.

Reset
REQ-017 While reset=0: state=IDLE, pending=0, ptr=0, scoreboard valid bits=0, issue_valid=0, WE3=0, done=0, instr_ready=1, all captured fields=0.
REQ-018 Reset asserted mid-ISSUE SHALL drop the instruction without a done pulse.

Structure
REQ-019 Package simd_pkg SHALL hold NUM_THREADS, PIPE_DEPTH, the sched_state_t enum, and the packed issue_t struct (funct4, imm, rs1, rs2, rd, is_int, is_float, we).
REQ-020 A sub-module thread_picker SHALL contain the rotating find-first-set from ptr, outputting the index and a found flag.

Verification
REQ-021 Accept with mask=16'h0005 and we=1, rd=3, rs1=1, no stall -> issue tIdx 0, then tIdx 2 on consecutive cycles, done with the second issue, then IDLE.
REQ-022 Two back-to-back instructions with mask=16'h0001: first writes rd=5, second reads rs1=5 -> second issue is delayed until the scoreboard clears: 3 bubble cycles with issue_valid=0 and WE3=0.
REQ-023 Same as REQ-022 but the second instruction has FUNCT4[4]=1 and rs2=5, rs1=0 -> no hazard bubble.
REQ-024 stall_in held high for 4 cycles mid-ISSUE with mask=16'hFFFF -> stall=1, issue_valid=0, pending and scoreboard unchanged; issue resumes at the same tIdx.
REQ-025 Accept with mask=0 -> done pulse in the next cycle, no issue_valid, instr_ready stays 1.
REQ-026 Reset pulled low after 2 of 4 issues (mask=16'h000F) -> all outputs at REQ-017 values immediately; no done pulse; the next accept starts again at tIdx 0.
